mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/mmio_out_fifo.sv | 50 +++++
 rtl/mmio_ctrl.sv | 144 ++++++++++++++
 tb/tb_mmio_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared address map, button indices and access-select type for the MMIO bridge.
package mmio_pkg;

  localparam logic [31:0] ADDR_OUT     = 32'd2000;
  localparam logic [31:0] ADDR_BTNL    = 32'd3000;
  localparam logic [31:0] ADDR_BTNR    = 32'd4000;
  localparam logic [31:0] ADDR_BTNU    = 32'd5000;
  localparam logic [31:0] ADDR_BTND    = 32'd6000;
  localparam logic [31:0] ADDR_VGASTAT = 32'd7000;
  localparam logic [31:0] ADDR_QSTAT   = 32'd7001;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT,
    SEL_BTNL,
    SEL_BTNR,
    SEL_BTNU,
    SEL_BTND,
    SEL_VGASTAT,
    SEL_QSTAT
  } sel_e;

  // Full 32-bit compare, so RAM aliases of the MMIO addresses stay RAM.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    sel_e sel;
    case (addr)
      ADDR_OUT:     sel = SEL_OUT;
      ADDR_BTNL:    sel = SEL_BTNL;
      ADDR_BTNR:    sel = SEL_BTNR;
      ADDR_BTNU:    sel = SEL_BTNU;
      ADDR_BTND:    sel = SEL_BTND;
      ADDR_VGASTAT: sel = SEL_VGASTAT;
      ADDR_QSTAT:   sel = SEL_QSTAT;
      default:      sel = SEL_RAM;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_out_fifo.sv
// Output word queue feeding the VGA stream; caller guarantees push/pop legality.
module mmio_out_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = empty ? 32'h0 : r_mem[r_rd_ptr];

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Processor data-memory bridge: RAM pass-through plus buttons, VGA status and output queue.
// Define MMIO_BTN_LATCH_EN to make button reads return sticky rising-edge bits.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int RAM_AW    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  output logic [31:0]       q_dmem,
  output logic              ram_wEn,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_dataIn,
  input  logic [31:0]       ram_dataOut,
  input  logic [3:0]        btn,
  output logic [31:0]       vga_data,
  output logic              vga_valid,
  input  logic              vga_ready,
  input  logic [31:0]       vga_status
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  sel_e        w_sel;
  logic        w_rd;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [4:0]  w_count5;
  logic [31:0] w_head;
  logic        w_ovf_set;
  logic        w_qstat_rd;
  logic [3:0]  w_btn_val;
  logic [31:0] w_rd_val;

  logic [3:0]  r_btn_meta;
  logic [3:0]  r_btn_sync;
  logic        r_ovf;
  sel_e        r_sel;
  logic [31:0] r_rd_data;

  assign w_sel      = decode_addr(address_dmem);
  assign w_rd       = ~wren;
  assign ram_wEn    = wren && (w_sel == SEL_RAM);
  assign ram_addr   = address_dmem[RAM_AW-1:0];
  assign ram_dataIn = data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
    end
  end

`ifdef MMIO_BTN_LATCH_EN
  logic [3:0] r_btn_prev;
  logic [3:0] r_btn_sticky;
  logic [3:0] w_btn_rise;
  logic [3:0] w_btn_clr;

  assign w_btn_rise = r_btn_sync & ~r_btn_prev;
  assign w_btn_clr  = {w_rd && (w_sel == SEL_BTND), w_rd && (w_sel == SEL_BTNU),
                       w_rd && (w_sel == SEL_BTNR), w_rd && (w_sel == SEL_BTNL)};

  // A new edge wins over a clearing read so no press is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_prev   <= '0;
      r_btn_sticky <= '0;
    end else begin
      r_btn_prev   <= r_btn_sync;
      r_btn_sticky <= (r_btn_sticky & ~w_btn_clr) | w_btn_rise;
    end
  end

  assign w_btn_val = r_btn_sticky;
`else
  assign w_btn_val = r_btn_sync;
`endif

  assign w_push_req = wren && (w_sel == SEL_OUT);
  assign w_pop      = ~w_empty & vga_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_qstat_rd = w_rd && (w_sel == SEL_QSTAT);

  mmio_out_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign w_count5  = 5'(w_count);
  assign vga_valid = ~w_empty;
  assign vga_data  = w_head;

  // Setting has priority so an overflow coincident with a status read survives it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else        r_ovf <= w_ovf_set | (r_ovf & ~w_qstat_rd);
  end

  always_comb begin
    w_rd_val = 32'h0;
    case (w_sel)
      SEL_BTNL:    w_rd_val = {31'b0, w_btn_val[BTN_L]};
      SEL_BTNR:    w_rd_val = {31'b0, w_btn_val[BTN_R]};
      SEL_BTNU:    w_rd_val = {31'b0, w_btn_val[BTN_U]};
      SEL_BTND:    w_rd_val = {31'b0, w_btn_val[BTN_D]};
      SEL_VGASTAT: w_rd_val = vga_status;
      SEL_QSTAT:   w_rd_val = {r_ovf, 26'b0, w_count5};
      default:     w_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel     <= SEL_RAM;
      r_rd_data <= 32'h0;
    end else begin
      r_sel     <= w_sel;
      r_rd_data <= w_rd_val;
    end
  end

  assign q_dmem = (r_sel == SEL_RAM) ? ram_dataOut : r_rd_data;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: vector table for single accesses, hand sequences for queue/button/reset cases.
module tb_mmio_ctrl;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [3:0]  btn;
  logic [31:0] vga_data;
  logic        vga_valid;
  logic        vga_ready;
  logic [31:0] vga_status;

  int checks = 0;
  int errors = 0;

  mmio_ctrl #(.OUT_DEPTH(4), .RAM_AW(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_dmem       (q_dmem),
    .ram_wEn      (ram_wEn),
    .ram_addr     (ram_addr),
    .ram_dataIn   (ram_dataIn),
    .ram_dataOut  (ram_dataOut),
    .btn          (btn),
    .vga_data     (vga_data),
    .vga_valid    (vga_valid),
    .vga_ready    (vga_ready),
    .vga_status   (vga_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM standing in for the processor's data memory.
  logic [31:0] ram_mem [4096];
  int          ram_wr_cnt = 0;
  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
    ram_dataOut = 32'h0;
  end
  always @(posedge clock) begin
    if (ram_wEn) begin
      ram_mem[ram_addr] <= ram_dataIn;
      ram_wr_cnt <= ram_wr_cnt + 1;
    end
    ram_dataOut <= ram_mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] vstat;
    logic        chk;
    logic [31:0] exp_q;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1; address_dmem = a; data = d;
    step();
    wren = 1'b0; address_dmem = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wren = 1'b0; address_dmem = a;
    step();
    q = q_dmem;
    address_dmem = 32'h0;
  endtask

  logic [31:0] q;
  int          wr_before;

  initial begin
    vecs[0]  = '{1'b1, 32'd100,      32'h12345678, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[1]  = '{1'b1, 32'd200,      32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 32'd100,      32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0};
    vecs[3]  = '{1'b0, 32'd200,      32'h0,        32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'd7000,     32'hFFFFFFFF, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'd7000,     32'h0,        32'hA5A50001, 1'b1, 32'hA5A50001, 1'b0};
    vecs[6]  = '{1'b1, 32'd7001,     32'hFFFFFFFF, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'd7001,     32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 32'd3000,     32'h1,        32'h0,        1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'd3000,     32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 32'd6000,     32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 32'h00001064, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'd100,      32'h0,        32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b1, 32'h00011B58, 32'h00000055, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h00011B58, 32'h0,        32'h0,        1'b1, 32'h00000055, 1'b0};

    reset = 1'b0; wren = 1'b0; address_dmem = 32'h0; data = 32'h0;
    btn = 4'h0; vga_ready = 1'b0; vga_status = 32'h0;

    // Reset-time outputs and write gating, checked between edges.
    wren = 1'b1; address_dmem = 32'd2000;
    #1;
    check("rst_wen_mmio", {31'b0, ram_wEn}, 32'h0);
    address_dmem = 32'd100;
    #1;
    check("rst_wen_ram", {31'b0, ram_wEn}, 32'h1);
    wren = 1'b0; address_dmem = 32'h0;
    check("rst_vga_valid", {31'b0, vga_valid}, 32'h0);
    check("rst_vga_data", vga_data, 32'h0);
    step(); step();
    check("rst_q_ram_path", q_dmem, ram_dataOut);
    reset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      wren = vecs[i].we; address_dmem = vecs[i].addr;
      data = vecs[i].wdata; vga_status = vecs[i].vstat;
      #1;
      check($sformatf("vec%0d_wen", i), {31'b0, ram_wEn}, {31'b0, vecs[i].exp_wen});
      step();
      if (vecs[i].chk) check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
    end
    wren = 1'b0; address_dmem = 32'h0;

    // OUT write goes to the queue, never to RAM (2000 aliases RAM word 0x7D0).
    wr_before = ram_wr_cnt;
    wren = 1'b1; address_dmem = 32'd2000; data = 32'h12345678;
    #1;
    check("out_wen", {31'b0, ram_wEn}, 32'h0);
    step();
    wren = 1'b0; address_dmem = 32'h0;
    check("out_ram_untouched", ram_wr_cnt, wr_before);
    check("out_valid", {31'b0, vga_valid}, 32'h1);
    check("out_data", vga_data, 32'h12345678);
    rd(32'h000007D0, q);
    check("out_alias_ram", q, 32'h0);
    vga_ready = 1'b1;
    step();
    vga_ready = 1'b0;
    check("out_drained", {31'b0, vga_valid}, 32'h0);

    // VGASTAT is captured at the access edge.
    vga_status = 32'h0BADF00D; wren = 1'b0; address_dmem = 32'd7000;
    @(posedge clock);
    #1;
    vga_status = 32'h11111111; address_dmem = 32'h0;
    #1;
    check("vgastat_sampled", q_dmem, 32'h0BADF00D);
    vga_status = 32'h0;

    // Fill to depth, then one dropped push.
    for (int i = 1; i <= 5; i++) wr(32'd2000, 32'(i));
    check("full_head", vga_data, 32'h1);
    rd(32'd7001, q);
    check("qstat_ovf", q, 32'h80000004);
    rd(32'd7001, q);
    check("qstat_cleared", q, 32'h00000004);

    // Push while full but popping in the same cycle is accepted.
    vga_ready = 1'b1; wren = 1'b1; address_dmem = 32'd2000; data = 32'h9;
    step();
    vga_ready = 1'b0; wren = 1'b0; address_dmem = 32'h0;
    check("pp_head", vga_data, 32'h2);
    rd(32'd7001, q);
    check("pp_qstat", q, 32'h00000004);
    vga_ready = 1'b1;
    step(); check("drain_3", vga_data, 32'h3);
    step(); check("drain_4", vga_data, 32'h4);
    step(); check("drain_9", vga_data, 32'h9);
    step(); check("drain_empty", {31'b0, vga_valid}, 32'h0);
    vga_ready = 1'b0;

`ifdef MMIO_BTN_LATCH_EN
    btn = 4'b0001;
    step(); step(); step();
    btn = 4'b0000;
    step(); step(); step();
    rd(32'd3000, q);
    check("btnl_latch_first", q, 32'h1);
    rd(32'd3000, q);
    check("btnl_latch_second", q, 32'h0);
    rd(32'd4000, q);
    check("btnr_latch_idle", q, 32'h0);
`else
    btn = 4'b0001;
    step(); step();
    rd(32'd3000, q);
    check("btnl_level_held", q, 32'h1);
    rd(32'd4000, q);
    check("btnr_level_idle", q, 32'h0);
    btn = 4'b0100;
    step(); step();
    rd(32'd5000, q);
    check("btnu_level_held", q, 32'h1);
    rd(32'd3000, q);
    check("btnl_level_released", q, 32'h0);
    btn = 4'b0000;
`endif

    // Reset mid-transfer drops the queue immediately.
    for (int i = 0; i < 3; i++) wr(32'd2000, 32'hA0 + 32'(i));
    check("pre_rst_valid", {31'b0, vga_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, vga_valid}, 32'h0);
    check("async_rst_data", vga_data, 32'h0);
    step(); step();
    reset = 1'b1;
    step();
    rd(32'd7001, q);
    check("post_rst_qstat", q, 32'h0);
    vga_ready = 1'b1;
    step();
    check("post_rst_no_replay", {31'b0, vga_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
